// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: 1 start, N data bits LSB first, 1 stop, no parity
module uart_tx #(
   parameter int N        = 8,
   parameter int BAUD     = 9600,
   parameter int CLK_FREQ = 100_000_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid,
   input  logic [N-1:0] data,
   output logic         ack,
   output logic         busy,
   output logic         tx
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int BCW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BNW = $clog2(N) + 1;
   localparam logic [BCW-1:0] BC_LAST = BCW'(DIV - 1);
   localparam logic [BNW-1:0] BN_LAST = BNW'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t         state, state_n;
   logic [BCW-1:0] bc, bc_n;
   logic [BNW-1:0] bn, bn_n;
   logic [N-1:0]   shreg, shreg_n, shreg_sh;
   logic           tx_n, busy_n, ack_n;

   // Register state, counters, shift register and all outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         bc    <= '0;
         bn    <= '0;
         shreg <= '0;
         tx    <= 1'b1;
         busy  <= 1'b0;
         ack   <= 1'b0;
      end else begin
         state <= state_n;
         bc    <= bc_n;
         bn    <= bn_n;
         shreg <= shreg_n;
         tx    <= tx_n;
         busy  <= busy_n;
         ack   <= ack_n;
      end
   end

   // Next-state and next-output logic; outputs are precomputed so tx/busy/ack stay registered
   always_comb begin
      state_n  = state;
      bc_n     = bc + 1'b1;
      bn_n     = bn;
      shreg_n  = shreg;
      tx_n     = tx;
      busy_n   = busy;
      ack_n    = 1'b0;
      shreg_sh = shreg >> 1;
      case (state)
         IDLE: begin
            bc_n   = '0;
            bn_n   = '0;
            tx_n   = 1'b1;
            busy_n = 1'b0;
            if (valid) begin
               shreg_n = data;
               ack_n   = 1'b1;
               tx_n    = 1'b0;
               busy_n  = 1'b1;
               state_n = START;
            end
         end
         START: begin
            if (bc == BC_LAST) begin
               state_n = DATA;
               bc_n    = '0;
               bn_n    = '0;
               tx_n    = shreg[0];
            end
         end
         DATA: begin
            if (bc == BC_LAST) begin
               bc_n    = '0;
               shreg_n = shreg_sh;
               if (bn == BN_LAST) begin
                  state_n = STOP;
                  bn_n    = '0;
                  tx_n    = 1'b1;
               end else begin
                  bn_n = bn + 1'b1;
                  tx_n = shreg_sh[0];
               end
            end
         end
         STOP: begin
            if (bc == BC_LAST) begin
               bc_n = '0;
               bn_n = '0;
               // Chaining straight into the next start bit leaves no idle gap
               if (valid) begin
                  shreg_n = data;
                  ack_n   = 1'b1;
                  tx_n    = 1'b0;
                  state_n = START;
               end else begin
                  tx_n    = 1'b1;
                  busy_n  = 1'b0;
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
            bc_n    = '0;
            bn_n    = '0;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with a line-decoding monitor
module tb_uart_tx;

   localparam int N     = 8;
   localparam int DIV   = 10;
   localparam int FRAME = (N + 2) * DIV;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid;
   logic [N-1:0] data;
   logic         ack, busy, tx;

   int           n_total = 0;
   int           n_pass  = 0;
   int           ack_cnt = 0;
   int           cyc     = 0;
   logic         prev_ack = 1'b0;
   logic [N-1:0] exp_q[$];

   uart_tx #(.N(N), .BAUD(10), .CLK_FREQ(100)) dut (
      .clk  (clk),
      .rst  (rst),
      .valid(valid),
      .data (data),
      .ack  (ack),
      .busy (busy),
      .tx   (tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   // ack must be a single-cycle pulse and only accompany a frame
   always @(negedge clk) begin
      if (ack === 1'b1) begin
         ack_cnt++;
         check("ack_single_pulse", {31'd0, prev_ack}, 0);
         check("busy_with_ack", {31'd0, busy}, 1);
      end
      prev_ack = ack;
   end

   // Line monitor: decodes each frame and compares against the expected word
   initial begin
      logic [N-1:0] w, rxw, tmp;
      logic         exp_bit;
      int           bad;
      bit           aborted, have;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0 || tx !== 1'b0) continue;
         have = (exp_q.size() > 0);
         if (have) w = exp_q.pop_front();
         else begin
            w = '0;
            check("unexpected_frame", 1, 0);
         end
         bad = 0; aborted = 0; rxw = '0;
         for (int b = 0; b < N + 2 && !aborted; b++) begin
            for (int c = 0; c < DIV && !aborted; c++) begin
               if (b != 0 || c != 0) @(negedge clk);
               if (rst !== 1'b0) aborted = 1;
               else begin
                  if (b == 0) exp_bit = 1'b0;
                  else if (b == N + 1) exp_bit = 1'b1;
                  else begin
                     tmp = w >> (b - 1);
                     exp_bit = tmp[0];
                  end
                  if (tx !== exp_bit || busy !== 1'b1) bad++;
                  if (c == DIV / 2 && b >= 1 && b <= N) rxw[b-1] = tx;
               end
            end
         end
         if (!aborted && have) begin
            check("rx_word", {24'd0, rxw}, {24'd0, w});
            check("frame_bad_samples", bad, 0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ack(output int t);
      int i;
      for (i = 0; i < 400; i++) begin
         @(negedge clk);
         if (ack === 1'b1) break;
      end
      check("ack_within_budget", {31'd0, (i < 400)}, 1);
      t = cyc;
   endtask

   task automatic wait_idle(output int t);
      int i;
      for (i = 0; i < 400; i++) begin
         @(negedge clk);
         if (busy === 1'b0) break;
      end
      check("idle_within_budget", {31'd0, (i < 400)}, 1);
      t = cyc;
   endtask

   task automatic send(input logic [N-1:0] w, output int t);
      exp_q.push_back(w);
      data  = w;
      valid = 1'b1;
      wait_ack(t);
      valid = 1'b0;
      data  = N'($urandom);
   endtask

   task automatic single(input logic [N-1:0] w);
      int a0, t0, t1;
      a0 = ack_cnt;
      send(w, t0);
      wait_idle(t1);
      check("frame_length", t1 - t0, FRAME);
      check("single_ack_count", ack_cnt - a0, 1);
   endtask

   task automatic b2b(input logic [N-1:0] a, input logic [N-1:0] b);
      int a0, t1, t2, ti;
      a0 = ack_cnt;
      exp_q.push_back(a);
      data  = a;
      valid = 1'b1;
      wait_ack(t1);
      exp_q.push_back(b);
      data = b;
      wait_ack(t2);
      valid = 1'b0;
      data  = N'($urandom);
      check("b2b_ack_spacing", t2 - t1, FRAME);
      wait_idle(ti);
      check("b2b_ack_count", ack_cnt - a0, 2);
      check("b2b_total_length", ti - t1, 2 * FRAME);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0, t1, a0;
      logic [N-1:0] w;
      rst = 1'b1; valid = 1'b1; data = 8'hA5;

      // Reset holds the line idle and swallows valid
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("reset_tx", {31'd0, tx}, 1);
         check("reset_busy", {31'd0, busy}, 0);
         check("reset_ack", {31'd0, ack}, 0);
      end
      rst = 1'b0; valid = 1'b0;
      tick(5);
      check("reset_no_capture", ack_cnt, 0);
      check("reset_idle_tx", {31'd0, tx}, 1);

      single(8'hA5);

      b2b(8'h00, 8'hFF);

      // valid pulsed mid-DATA must be ignored
      a0 = ack_cnt;
      send(8'h5A, t0);
      tick(35);
      valid = 1'b1; data = 8'h3C;
      @(negedge clk);
      valid = 1'b0;
      wait_idle(t1);
      tick(5);
      check("midframe_valid_acks", ack_cnt - a0, 1);
      check("midframe_valid_tx_idle", {31'd0, tx}, 1);
      check("midframe_valid_busy", {31'd0, busy}, 0);

      // data changed right after ack must not affect the frame
      send(8'hC3, t0);
      data = 8'h00;
      wait_idle(t1);
      check("hold_frame_length", t1 - t0, FRAME);

      // reset in the middle of a frame
      send(8'h77, t0);
      tick(44);
      rst = 1'b1;
      @(negedge clk);
      check("midreset_tx", {31'd0, tx}, 1);
      check("midreset_busy", {31'd0, busy}, 0);
      check("midreset_ack", {31'd0, ack}, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      tick(3);
      single(8'h81);

      // randomized traffic
      for (int i = 0; i < 10; i++) begin
         w = N'($urandom);
         if ($urandom_range(0, 2) == 0) b2b(w, N'($urandom));
         else single(w);
         tick($urandom_range(0, 15));
      end

      tick(20);
      check("scoreboard_empty", exp_q.size(), 0);
      check("final_tx_idle", {31'd0, tx}, 1);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
